// File: rtl/wash_pkg.sv
// Shared types, per-mode schedules and pricing helpers for the wash-cycle sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    StIdle, StCheck, StFill1, StWash, StFill2, StRinse, StSpin, StDone
  } state_e;

  localparam logic [1:0] ModeStd    = 2'b00;
  localparam logic [1:0] ModeQuick  = 2'b01;
  localparam logic [1:0] ModeCustom = 2'b10;
  localparam logic [1:0] ModeSpin   = 2'b11;

  localparam logic [4:0] CustomMax = 5'd20;

  typedef struct packed {
    logic [4:0] fill1;
    logic [4:0] wash;
    logic [4:0] fill2;
    logic [4:0] rinse;
    logic [4:0] spin;
    logic [9:0] price;
  } sched_t;

  localparam sched_t SchedStd   = '{fill1: 5'd1, wash: 5'd6, fill2: 5'd1, rinse: 5'd4,
                                    spin: 5'd2, price: 10'd8};
  localparam sched_t SchedQuick = '{fill1: 5'd1, wash: 5'd3, fill2: 5'd1, rinse: 5'd2,
                                    spin: 5'd1, price: 10'd5};
  localparam sched_t SchedSpin  = '{fill1: 5'd0, wash: 5'd0, fill2: 5'd0, rinse: 5'd0,
                                    spin: 5'd3, price: 10'd2};

  function automatic logic [9:0] custom_price(logic [4:0] set_time);
    return 10'd4 + {5'd0, set_time};
  endfunction

  function automatic logic set_time_ok(logic [4:0] set_time);
    return (set_time != 5'd0) && (set_time <= CustomMax);
  endfunction

  function automatic sched_t get_sched(logic [1:0] mode, logic [4:0] set_time);
    sched_t s;
    case (mode)
      ModeStd:    s = SchedStd;
      ModeQuick:  s = SchedQuick;
      ModeCustom: s = '{fill1: 5'd1, wash: set_time, fill2: 5'd1, rinse: 5'd2, spin: 5'd2,
                        price: custom_price(set_time)};
      default:    s = SchedSpin;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] sched_total(sched_t s);
    return 8'(s.fill1) + 8'(s.wash) + 8'(s.fill2) + 8'(s.rinse) + 8'(s.spin);
  endfunction

  function automatic logic [4:0] phase_dur(state_e st, sched_t s);
    logic [4:0] d;
    case (st)
      StFill1: d = s.fill1;
      StWash:  d = s.wash;
      StFill2: d = s.fill2;
      StRinse: d = s.rinse;
      StSpin:  d = s.spin;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  // Later assignments win, so the earliest non-empty phase after cur is selected.
  function automatic state_e next_phase(state_e cur, sched_t s);
    state_e nxt;
    nxt = StDone;
    if (cur < StSpin  && s.spin  != 5'd0) nxt = StSpin;
    if (cur < StRinse && s.rinse != 5'd0) nxt = StRinse;
    if (cur < StFill2 && s.fill2 != 5'd0) nxt = StFill2;
    if (cur < StWash  && s.wash  != 5'd0) nxt = StWash;
    if (cur < StFill1 && s.fill1 != 5'd0) nxt = StFill1;
    return nxt;
  endfunction

endpackage

// File: rtl/wash_tick.sv
// Time-unit divider: emits a one-cycle tick every TICK_DIV enabled cycles.
module wash_tick #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wash_seq.sv
// Wash-cycle sequencer: charge, FILL/WASH/RINSE/SPIN sequencing, pause and door interlock.
// Define WASH_ALARM_EN to sound the buzzer for 3 units after a cycle completes.
module wash_seq
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100000000,
  parameter bit          SPIN_SPEED_HI = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       door_open,
  input  logic [1:0] mode,
  input  logic [4:0] set_time,
  input  logic [9:0] bal_in,
  output logic [9:0] bal_out,
  output logic       bal_load,
  output logic       valve,
  output logic       drain,
  output logic       motor,
  output logic       motor_hi,
  output logic [2:0] phase,
  output logic [7:0] remain,
  output logic       busy,
  output logic       paused,
  output logic       done,
  output logic       err,
  output logic       buzzer
);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [4:0] set_time_q, set_time_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] remain_q, remain_d;
  logic [9:0] bal_out_q, bal_out_d;
  logic       bal_load_q, bal_load_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       paused_q, paused_d;

  sched_t sched;
  state_e first, nxt;
  logic   ok, run, frz, tick, tick_clr, tick_en, alarm_run;

  assign sched = get_sched(mode_q, set_time_q);
  assign ok    = (mode_q != ModeCustom) || set_time_ok(set_time_q);
  assign busy  = state_q inside {StFill1, StWash, StFill2, StRinse, StSpin};
  // A pause pulse or open door freezes the divider in the very cycle it arrives.
  assign frz      = paused_q || (busy && (pause || door_open));
  assign tick_clr = (state_q == StCheck);
  assign tick_en  = (busy && !frz) || alarm_run;

  wash_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    set_time_d = set_time_q;
    cnt_d      = cnt_q;
    remain_d   = remain_q;
    bal_out_d  = bal_out_q;
    bal_load_d = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    paused_d   = paused_q;
    first      = next_phase(StCheck, sched);
    nxt        = next_phase(state_q, sched);
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StCheck;
          mode_d     = mode;
          set_time_d = set_time;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      StCheck: begin
        if (!ok || (bal_in < sched.price)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          bal_out_d  = bal_in - sched.price;
          bal_load_d = 1'b1;
          state_d    = first;
          cnt_d      = phase_dur(first, sched);
          remain_d   = sched_total(sched);
        end
      end
      StFill1, StWash, StFill2, StRinse, StSpin: begin
        if (pause) begin
          paused_d = paused_q ? door_open : 1'b1;
        end else if (door_open) begin
          paused_d = 1'b1;
        end
        if (tick) begin
          remain_d = remain_q - 8'd1;
          if (cnt_q == 5'd1) begin
            state_d = nxt;
            cnt_d   = phase_dur(nxt, sched);
            if (nxt == StDone) begin
              done_d   = 1'b1;
              remain_d = 8'd0;
            end
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      set_time_q <= 5'd0;
      cnt_q      <= 5'd0;
      remain_q   <= 8'd0;
      bal_out_q  <= 10'd0;
      bal_load_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      set_time_q <= set_time_d;
      cnt_q      <= cnt_d;
      remain_q   <= remain_d;
      bal_out_q  <= bal_out_d;
      bal_load_q <= bal_load_d;
      done_q     <= done_d;
      err_q      <= err_d;
      paused_q   <= paused_d;
    end
  end

`ifdef WASH_ALARM_EN
  logic [1:0] alarm_q, alarm_d;

  assign alarm_run = (state_q == StDone) && (alarm_q != 2'd3);
  assign buzzer    = alarm_run;

  always_comb begin
    alarm_d = alarm_q;
    if (state_q != StDone && state_d == StDone) begin
      alarm_d = 2'd0;
    end else if (alarm_run && tick) begin
      alarm_d = alarm_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 2'd3;
    end else begin
      alarm_q <= alarm_d;
    end
  end
`else
  assign alarm_run = 1'b0;
  assign buzzer    = 1'b0;
`endif

  assign run = !paused_q;

  always_comb begin
    phase    = 3'b000;
    valve    = 1'b0;
    drain    = 1'b0;
    motor    = 1'b0;
    motor_hi = 1'b0;
    unique case (state_q)
      StFill1, StFill2: begin
        phase = 3'b001;
        valve = run;
      end
      StWash: begin
        phase = 3'b001;
        motor = run;
      end
      StRinse: begin
        phase = 3'b010;
        motor = run;
      end
      StSpin: begin
        phase    = 3'b100;
        drain    = run;
        motor    = run;
        motor_hi = run && SPIN_SPEED_HI;
      end
      default: ;
    endcase
  end

  assign bal_out  = bal_out_q;
  assign bal_load = bal_load_q;
  assign remain   = remain_q;
  assign paused   = paused_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wash_seq.sv
// Randomised self-checking bench for wash_seq against a unit-level schedule model (TICK_DIV=4).
module tb_wash_seq;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, door_open = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [4:0] set_time = 5'd0;
  logic [9:0] bal_in = 10'd0;
  logic [9:0] bal_out;
  logic       bal_load, valve, drain, motor, motor_hi, busy, paused, done, err, buzzer;
  logic [2:0] phase;
  logic [7:0] remain;

  int n_pass = 0;
  int n_total = 0;

  wash_seq #(
    .TICK_DIV      (TD),
    .SPIN_SPEED_HI (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .door_open (door_open),
    .mode      (mode),
    .set_time  (set_time),
    .bal_in    (bal_in),
    .bal_out   (bal_out),
    .bal_load  (bal_load),
    .valve     (valve),
    .drain     (drain),
    .motor     (motor),
    .motor_hi  (motor_hi),
    .phase     (phase),
    .remain    (remain),
    .busy      (busy),
    .paused    (paused),
    .done      (done),
    .err       (err),
    .buzzer    (buzzer)
  );

  always #5 clk = ~clk;

  // Durations in order FILL1, WASH, FILL2, RINSE, SPIN.
  function automatic int dur(int m, int st, int p);
    int t[4][5];
    t[0] = '{1, 6, 1, 4, 2};
    t[1] = '{1, 3, 1, 2, 1};
    t[2] = '{1, st, 1, 2, 2};
    t[3] = '{0, 0, 0, 0, 3};
    return t[m][p];
  endfunction

  function automatic int total_of(int m, int st);
    int s = 0;
    for (int p = 0; p < 5; p++) s += dur(m, st, p);
    return s;
  endfunction

  function automatic int price_of(int m, int st);
    case (m)
      0: return 8;
      1: return 5;
      2: return 4 + st;
      default: return 2;
    endcase
  endfunction

  // Expected {bal_load,busy,paused,done,valve,drain,motor,motor_hi,phase,remain} after k active cycles.
  function automatic logic [18:0] model_out(int m, int st, int k, bit pz);
    int total, u, acc, p;
    logic [2:0] lights;
    bit v, d, mo, hi;
    total = total_of(m, st);
    if (k >= total * TD) return {1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 8'd0};
    u = k / TD;
    acc = 0;
    p = 4;
    for (int i = 0; i < 5; i++) begin
      acc += dur(m, st, i);
      if (u < acc) begin
        p = i;
        break;
      end
    end
    lights = (p <= 2) ? 3'b001 : (p == 3) ? 3'b010 : 3'b100;
    v  = !pz && (p == 0 || p == 2);
    mo = !pz && (p == 1 || p == 3 || p == 4);
    d  = !pz && (p == 4);
    hi = !pz && (p == 4);
    return {1'b0, 1'b1, pz, 1'b0, v, d, mo, hi, lights, 8'(total - u)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({bal_out, bal_load, valve, drain, motor, motor_hi, phase, remain, busy, paused, done, err,
         buzzer} !== '0)
      $display("FAIL reset: got bal_out=%0d phase=%b remain=%0d busy=%b done=%b err=%b, want all 0",
               bal_out, phase, remain, busy, done, err);
    else n_pass++;
    rst = 1'b0;
  endtask

  // One full start..done (or refused) job; pause_at >= 0 plays the fixed pause/door script.
  task automatic test_job(input string name, input int m, input int st, input int bal,
                          input int pause_at, input bit noise);
    int price, total, k, c, frozen, hi_cnt;
    bit bad, pz, pin, din, fr;
    logic [18:0] exp_v, obs_v;
    price = price_of(m, st);
    total = total_of(m, st);
    bad = (m == 2 && (st < 1 || st > 20)) || (bal < price);
    @(posedge clk);
    #1;
    mode = 2'(m); set_time = 5'(st); bal_in = 10'(bal); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mode = 2'($urandom); set_time = 5'($urandom);
    n_total++;
    if ({done, err, bal_load} !== 3'b000)
      $display("FAIL %s start_clear: got done/err/load=%b want 000", name, {done, err, bal_load});
    else n_pass++;
    @(posedge clk);
    #1;
    if (bad) begin
      n_total++;
      if ({err, bal_load, busy} !== 3'b100)
        $display("FAIL %s refuse: got err/load/busy=%b want 100", name, {err, bal_load, busy});
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if ({err, bal_load, busy, remain} !== {3'b100, 8'd0})
        $display("FAIL %s refuse_hold: got err/load/busy=%b remain=%0d want 100 0", name,
                 {err, bal_load, busy}, remain);
      else n_pass++;
      return;
    end
    n_total++;
    if ({bal_load, busy, bal_out, remain} !== {2'b11, 10'(bal - price), 8'(total)})
      $display("FAIL %s charge: got load=%b busy=%b bal_out=%0d remain=%0d want 1 1 %0d %0d",
               name, bal_load, busy, bal_out, remain, bal - price, total);
    else n_pass++;
    k = 0; c = 0; frozen = 0; pz = 1'b0;
    while (1) begin
      pin = (pause_at >= 0) && (c == pause_at || c == pause_at + 55);
      din = (pause_at >= 0) && (c >= pause_at + 50) && (c <= pause_at + 52);
      if (noise) begin
        pin = pin || ($urandom_range(0, 18) == 0);
        din = din || ($urandom_range(0, 36) == 0);
        start = ($urandom_range(0, 16) == 0);
        mode = 2'($urandom);
      end
      pause = pin; door_open = din;
      @(posedge clk);
      #1;
      c++;
      fr = pz || pin || din;
      if (fr) frozen++;
      else k++;
      if (pin) pz = pz ? din : 1'b1;
      else if (din) pz = 1'b1;
      exp_v = model_out(m, st, k, pz);
      obs_v = {bal_load, busy, paused, done, valve, drain, motor, motor_hi, phase, remain};
      n_total++;
      if (obs_v !== exp_v)
        $display("FAIL %s cyc%0d: got %b want %b", name, c, obs_v, exp_v);
      else n_pass++;
      if (k >= total * TD) break;
      if (c > 3000) begin
        n_total++;
        $display("FAIL %s timeout: got no done after %0d cycles, want done", name, c);
        break;
      end
    end
    pause = 1'b0; door_open = 1'b0; start = 1'b0;
    n_total++;
    if (c !== total * TD + ((pause_at >= 0) ? 56 : frozen))
      $display("FAIL %s length: got %0d cycles want %0d", name, c,
               total * TD + ((pause_at >= 0) ? 56 : frozen));
    else n_pass++;
`ifdef WASH_ALARM_EN
    hi_cnt = 0;
    while (buzzer === 1'b1 && hi_cnt < 40) begin
      hi_cnt++;
      @(posedge clk);
      #1;
    end
    n_total++;
    if (hi_cnt !== 3 * TD) $display("FAIL %s buzzer: got %0d cycles high want %0d", name, hi_cnt,
                                    3 * TD);
    else n_pass++;
`else
    hi_cnt = 0;
    n_total++;
    if (buzzer !== 1'b0) $display("FAIL %s buzzer: got %b want 0", name, buzzer);
    else n_pass++;
`endif
  endtask

  task automatic test_rst_mid();
    int w;
    @(posedge clk);
    #1;
    mode = 2'd0; set_time = 5'd0; bal_in = 10'd20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (bal_load !== 1'b1 && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (40) @(posedge clk);
    #1;
    n_total++;
    if ({phase, motor} !== 4'b0101) $display("FAIL rst_mid rinse: got phase=%b motor=%b want 010 1",
                                            phase, motor);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if ({bal_out, bal_load, valve, drain, motor, motor_hi, phase, remain, busy, paused, done, err,
         buzzer} !== '0)
      $display("FAIL rst_mid: got bal_out=%0d phase=%b remain=%0d busy=%b load=%b want all 0",
               bal_out, phase, remain, busy, bal_load);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if ({busy, bal_load, done} !== 3'b000)
      $display("FAIL rst_mid idle: got busy/load/done=%b want 000", {busy, bal_load, done});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      test_job("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 21)),
               int'($urandom_range(0, 40)), -1, 1'b1);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_job("std", 0, 0, 20, -1, 1'b0);
    test_job("quick_poor", 1, 0, 4, -1, 1'b0);
    test_job("quick", 1, 0, 5, -1, 1'b0);
    test_job("spin_only", 3, 0, 2, -1, 1'b0);
    test_job("custom0", 2, 0, 30, -1, 1'b0);
    test_job("custom20", 2, 20, 30, -1, 1'b0);
    test_job("pause_door", 0, 0, 20, 10, 1'b0);
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
